// File: rtl/isa_irq_pkg.sv
// Shared constants for the ISA core's PC path and the vectored interrupt controller.
package isa_irq_pkg;

    // PC-mux select encodings; PCMUX_RETI selects the saved return address.
    localparam logic [1:0] PCMUX_NEXT = 2'b00;
    localparam logic [1:0] PCMUX_W    = 2'b01;
    localparam logic [1:0] PCMUX_LIT  = 2'b10;
    localparam logic [1:0] PCMUX_RETI = 2'b11;

    // Default program counter width of the ISA core.
    localparam int ISA_PC_WIDTH = 11;

endpackage

// File: rtl/irq_priority_encoder.sv
// Fixed-priority encoder: reports whether any request is set and the lowest set index.
module irq_priority_encoder #(
    parameter  int NUM_IRQ = 4,
    localparam int IDW     = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic [NUM_IRQ-1:0] req_i,
    output logic               valid_o,
    output logic [IDW-1:0]     idx_o
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                valid_o = 1'b1;
                idx_o   = IDW'(i);
            end
        end
    end

endmodule

// File: rtl/irq_vector_ctrl.sv
// Vectored, nesting interrupt controller placed between the PC mux and the PC.
// Accepting a request redirects pc_out to the channel vector and pushes pc_next
// with the channel id; a reti select pops one entry.
// Bookkeeping handshake: a request is consumed exactly in the cycle "accept" is
// high, and that is also the cycle pc_out carries the vector address.
module irq_vector_ctrl
    import isa_irq_pkg::*;
#(
    parameter  int                  NUM_IRQ       = 4,
    parameter  int                  PC_WIDTH      = ISA_PC_WIDTH,
    parameter  int                  STACK_DEPTH   = 2,
    parameter  logic [PC_WIDTH-1:0] VECTOR_BASE   = 'h004,
    parameter  int                  VECTOR_STRIDE = 2,
    parameter  logic [NUM_IRQ-1:0]  EDGE_MASK     = '0,
    localparam int                  IDW           = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
    localparam int                  DW            = $clog2(STACK_DEPTH + 1)
) (
    input  logic                instr_clock,
    input  logic                reset,
    input  logic [NUM_IRQ-1:0]  irq,
    input  logic [NUM_IRQ-1:0]  irq_enable,
    input  logic                global_ie,
    input  logic [1:0]          pc_mux_control,
    input  logic [PC_WIDTH-1:0] pc_next,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] pc_save,
    output logic                in_service,
    output logic [IDW-1:0]      active_id,
    output logic [NUM_IRQ-1:0]  pending
);

    logic [NUM_IRQ-1:0]  prev_q;
    logic [NUM_IRQ-1:0]  edge_pend_q, edge_pend_d;
    logic [DW-1:0]       depth_q, depth_d;
    logic [PC_WIDTH-1:0] stk_pc_q [STACK_DEPTH];
    logic [PC_WIDTH-1:0] stk_pc_d [STACK_DEPTH];
    logic [IDW-1:0]      stk_id_q [STACK_DEPTH];
    logic [IDW-1:0]      stk_id_d [STACK_DEPTH];

    logic                cand_valid;
    logic [IDW-1:0]      cand_idx;
    logic [PC_WIDTH-1:0] top_pc;
    logic [IDW-1:0]      top_id;
    logic                stack_empty, stack_full, is_reti, accept, pop;
    logic [NUM_IRQ-1:0]  clr_mask;

    // Edge channels report their latch; level channels pass the raw line through.
    assign pending = (edge_pend_q & EDGE_MASK) | (irq & ~EDGE_MASK);

    irq_priority_encoder #(.NUM_IRQ(NUM_IRQ)) u_prio (
        .req_i   (pending & irq_enable),
        .valid_o (cand_valid),
        .idx_o   (cand_idx)
    );

    // Select the top-of-stack entry; reads as zero when the stack is empty.
    always_comb begin
        top_pc = '0;
        top_id = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (depth_q == DW'(i + 1)) begin
                top_pc = stk_pc_q[i];
                top_id = stk_id_q[i];
            end
        end
    end

    assign stack_empty = (depth_q == '0);
    assign stack_full  = (depth_q == DW'(STACK_DEPTH));
    assign is_reti     = (pc_mux_control == PCMUX_RETI);

    // Only a strictly higher-priority channel may preempt a running handler.
    assign accept = !reset && global_ie && cand_valid && !is_reti && !stack_full &&
                    (stack_empty || (cand_idx < top_id));
    assign pop    = !reset && is_reti && !stack_empty;

    assign clr_mask = accept ? (NUM_IRQ'(1) << cand_idx) : '0;

    assign pc_out     = accept ? (VECTOR_BASE + PC_WIDTH'(cand_idx) * PC_WIDTH'(VECTOR_STRIDE))
                               : pc_next;
    assign pc_save    = top_pc;
    assign active_id  = top_id;
    assign in_service = !stack_empty;

    // Next state of the edge latches and the return stack.
    always_comb begin
        // A new edge in the accepting cycle re-arms the channel, so set wins over clear.
        edge_pend_d = ((edge_pend_q & ~clr_mask) | (irq & ~prev_q)) & EDGE_MASK;
        depth_d     = depth_q;
        stk_pc_d    = stk_pc_q;
        stk_id_d    = stk_id_q;
        if (accept) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (depth_q == DW'(i)) begin
                    stk_pc_d[i] = pc_next;
                    stk_id_d[i] = cand_idx;
                end
            end
            depth_d = depth_q + DW'(1);
        end else if (pop) begin
            depth_d = depth_q - DW'(1);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge instr_clock) begin
        if (reset) begin
            prev_q      <= '0;
            edge_pend_q <= '0;
            depth_q     <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stk_pc_q[i] <= '0;
                stk_id_q[i] <= '0;
            end
        end else begin
            prev_q      <= irq;
            edge_pend_q <= edge_pend_d;
            depth_q     <= depth_d;
            stk_pc_q    <= stk_pc_d;
            stk_id_q    <= stk_id_d;
        end
    end

endmodule

// File: tb/tb_irq_vector_ctrl.sv
// Bench for irq_vector_ctrl: directed vector table, a reset-mid-ISR sequence and
// randomized traffic checked against a queue-based model of the controller.
module tb_irq_vector_ctrl;

    localparam logic [3:0] EDGE = 4'b1110;  // channel 0 level, channels 1..3 edge

    logic        instr_clock = 1'b0;
    logic        reset;
    logic [3:0]  irq;
    logic [3:0]  irq_enable;
    logic        global_ie;
    logic [1:0]  pc_mux_control;
    logic [10:0] pc_next;
    logic [10:0] pc_out;
    logic [10:0] pc_save;
    logic        in_service;
    logic [1:0]  active_id;
    logic [3:0]  pending;

    int n_tests = 0;
    int n_fail  = 0;

    irq_vector_ctrl #(
        .NUM_IRQ(4), .PC_WIDTH(11), .STACK_DEPTH(2), .VECTOR_BASE(11'h004),
        .VECTOR_STRIDE(2), .EDGE_MASK(EDGE)
    ) dut (
        .instr_clock    (instr_clock),
        .reset          (reset),
        .irq            (irq),
        .irq_enable     (irq_enable),
        .global_ie      (global_ie),
        .pc_mux_control (pc_mux_control),
        .pc_next        (pc_next),
        .pc_out         (pc_out),
        .pc_save        (pc_save),
        .in_service     (in_service),
        .active_id      (active_id),
        .pending        (pending)
    );

    // clock
    always #5 instr_clock = ~instr_clock;

    // ---------------- reference model ----------------
    logic [10:0] m_pc[$];
    logic [1:0]  m_id[$];
    logic [3:0]  m_pend = '0;
    logic [3:0]  m_prev = '0;

    function automatic void model_eval(output logic acc, output int cand,
                                       output logic [10:0] e_pc, output logic [3:0] vis);
        int depth;
        int top;
        vis  = (m_pend & EDGE) | (irq & ~EDGE);
        cand = -1;
        for (int i = 3; i >= 0; i--) if (vis[i] && irq_enable[i]) cand = i;
        depth = m_pc.size();
        top   = (depth > 0) ? int'(m_id[depth-1]) : 0;
        acc   = !reset && global_ie && (cand >= 0) && (pc_mux_control != 2'b11) &&
                (depth < 2) && (depth == 0 || cand < top);
        e_pc  = acc ? 11'(4 + 2 * cand) : pc_next;
    endfunction

    function automatic void model_step();
        logic acc;
        int cand;
        logic [10:0] e_pc;
        logic [3:0] vis;
        model_eval(acc, cand, e_pc, vis);
        if (reset) begin
            m_pc.delete();
            m_id.delete();
            m_pend = '0;
            m_prev = '0;
        end else begin
            if (acc) begin
                m_pc.push_back(pc_next);
                m_id.push_back(2'(cand));
                m_pend[cand] = 1'b0;
            end else if (pc_mux_control == 2'b11 && m_pc.size() > 0) begin
                m_pc.delete(m_pc.size() - 1);
                m_id.delete(m_id.size() - 1);
            end
            for (int i = 0; i < 4; i++)
                if (EDGE[i] && irq[i] && !m_prev[i]) m_pend[i] = 1'b1;
            m_prev = irq;
        end
    endfunction

    // ---------------- driver / checker tasks ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic rst, input logic [3:0] i_irq, input logic [3:0] en,
                         input logic gie, input logic [1:0] mux, input logic [10:0] pcn);
        reset = rst; irq = i_irq; irq_enable = en; global_ie = gie;
        pc_mux_control = mux; pc_next = pcn;
        #2;
    endtask

    task automatic tick();
        model_step();
        @(posedge instr_clock);
        #1;
    endtask

    task automatic check_model();
        logic acc;
        int cand;
        logic [10:0] e_pc;
        logic [3:0] vis;
        int d;
        model_eval(acc, cand, e_pc, vis);
        d = m_pc.size();
        chk("rnd_pc_out", pc_out, e_pc);
        chk("rnd_pending", pending, vis);
        chk("rnd_in_service", in_service, (d > 0));
        chk("rnd_pc_save", pc_save, (d > 0) ? m_pc[d-1] : 11'h0);
        chk("rnd_active_id", active_id, (d > 0) ? m_id[d-1] : 2'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0]  irq;
        logic [3:0]  en;
        logic        gie;
        logic [1:0]  mux;
        logic [10:0] pcn;
        logic [10:0] e_pc;
        logic        e_srv;
        logic [1:0]  e_id;
        logic [10:0] e_save;
        logic [3:0]  e_pend;
    } vec_t;

    function automatic vec_t mk(logic [3:0] i_irq, logic [3:0] en, logic gie, logic [1:0] mux,
                                logic [10:0] pcn, logic [10:0] e_pc, logic e_srv,
                                logic [1:0] e_id, logic [10:0] e_save, logic [3:0] e_pend);
        vec_t v;
        v.irq = i_irq; v.en = en; v.gie = gie; v.mux = mux; v.pcn = pcn;
        v.e_pc = e_pc; v.e_srv = e_srv; v.e_id = e_id; v.e_save = e_save; v.e_pend = e_pend;
        return v;
    endfunction

    vec_t tbl[37];

    initial begin
        // single edge on channel 2, then reti
        tbl[0]  = mk(4'h0, 4'hF, 1, 2'd0, 11'h010, 11'h010, 0, 0, 11'h000, 4'h0);
        tbl[1]  = mk(4'h4, 4'hF, 1, 2'd0, 11'h010, 11'h010, 0, 0, 11'h000, 4'h0);
        tbl[2]  = mk(4'h0, 4'hF, 1, 2'd0, 11'h010, 11'h008, 0, 0, 11'h000, 4'h4);
        tbl[3]  = mk(4'h0, 4'hF, 1, 2'd0, 11'h009, 11'h009, 1, 2, 11'h010, 4'h0);
        tbl[4]  = mk(4'h0, 4'hF, 1, 2'd3, 11'h010, 11'h010, 1, 2, 11'h010, 4'h0);
        tbl[5]  = mk(4'h0, 4'hF, 1, 2'd0, 11'h011, 11'h011, 0, 0, 11'h000, 4'h0);
        // simultaneous edges on 3 and 1; 3 tail-chains after reti
        tbl[6]  = mk(4'hA, 4'hF, 1, 2'd0, 11'h020, 11'h020, 0, 0, 11'h000, 4'h0);
        tbl[7]  = mk(4'h0, 4'hF, 1, 2'd0, 11'h020, 11'h006, 0, 0, 11'h000, 4'hA);
        tbl[8]  = mk(4'h0, 4'hF, 1, 2'd0, 11'h007, 11'h007, 1, 1, 11'h020, 4'h8);
        tbl[9]  = mk(4'h0, 4'hF, 1, 2'd3, 11'h020, 11'h020, 1, 1, 11'h020, 4'h8);
        tbl[10] = mk(4'h0, 4'hF, 1, 2'd0, 11'h021, 11'h00A, 0, 0, 11'h000, 4'h8);
        tbl[11] = mk(4'h0, 4'hF, 1, 2'd0, 11'h00B, 11'h00B, 1, 3, 11'h021, 4'h0);
        // preemption by 2 inside 3, then 1 blocked by full stack
        tbl[12] = mk(4'h4, 4'hF, 1, 2'd0, 11'h00C, 11'h00C, 1, 3, 11'h021, 4'h0);
        tbl[13] = mk(4'h0, 4'hF, 1, 2'd0, 11'h00D, 11'h008, 1, 3, 11'h021, 4'h4);
        tbl[14] = mk(4'h2, 4'hF, 1, 2'd0, 11'h009, 11'h009, 1, 2, 11'h00D, 4'h0);
        tbl[15] = mk(4'h0, 4'hF, 1, 2'd0, 11'h00A, 11'h00A, 1, 2, 11'h00D, 4'h2);
        tbl[16] = mk(4'h0, 4'hF, 1, 2'd3, 11'h00D, 11'h00D, 1, 2, 11'h00D, 4'h2);
        tbl[17] = mk(4'h0, 4'hF, 1, 2'd0, 11'h00E, 11'h006, 1, 3, 11'h021, 4'h2);
        tbl[18] = mk(4'h0, 4'hF, 1, 2'd0, 11'h007, 11'h007, 1, 1, 11'h00E, 4'h0);
        tbl[19] = mk(4'h0, 4'hF, 1, 2'd3, 11'h00E, 11'h00E, 1, 1, 11'h00E, 4'h0);
        tbl[20] = mk(4'h0, 4'hF, 1, 2'd3, 11'h021, 11'h021, 1, 3, 11'h021, 4'h0);
        tbl[21] = mk(4'h0, 4'hF, 1, 2'd0, 11'h030, 11'h030, 0, 0, 11'h000, 4'h0);
        // masked edge stays pending, accepted once enabled
        tbl[22] = mk(4'h2, 4'hD, 1, 2'd0, 11'h040, 11'h040, 0, 0, 11'h000, 4'h0);
        tbl[23] = mk(4'h0, 4'hD, 1, 2'd0, 11'h041, 11'h041, 0, 0, 11'h000, 4'h2);
        tbl[24] = mk(4'h0, 4'hF, 1, 2'd0, 11'h042, 11'h006, 0, 0, 11'h000, 4'h2);
        tbl[25] = mk(4'h0, 4'hF, 1, 2'd0, 11'h007, 11'h007, 1, 1, 11'h042, 4'h0);
        tbl[26] = mk(4'h0, 4'hF, 1, 2'd3, 11'h042, 11'h042, 1, 1, 11'h042, 4'h0);
        // level channel 0: blocked by global_ie, re-accepted after reti while held
        tbl[27] = mk(4'h1, 4'hF, 0, 2'd0, 11'h050, 11'h050, 0, 0, 11'h000, 4'h1);
        tbl[28] = mk(4'h1, 4'hF, 1, 2'd0, 11'h051, 11'h004, 0, 0, 11'h000, 4'h1);
        tbl[29] = mk(4'h1, 4'hF, 1, 2'd0, 11'h005, 11'h005, 1, 0, 11'h051, 4'h1);
        tbl[30] = mk(4'h1, 4'hF, 1, 2'd3, 11'h051, 11'h051, 1, 0, 11'h051, 4'h1);
        tbl[31] = mk(4'h1, 4'hF, 1, 2'd0, 11'h052, 11'h004, 0, 0, 11'h000, 4'h1);
        tbl[32] = mk(4'h0, 4'hF, 1, 2'd0, 11'h005, 11'h005, 1, 0, 11'h052, 4'h0);
        tbl[33] = mk(4'h0, 4'hF, 1, 2'd3, 11'h052, 11'h052, 1, 0, 11'h052, 4'h0);
        tbl[34] = mk(4'h0, 4'hF, 1, 2'd0, 11'h053, 11'h053, 0, 0, 11'h000, 4'h0);
        // level request dropped before it could be accepted
        tbl[35] = mk(4'h1, 4'hF, 0, 2'd0, 11'h060, 11'h060, 0, 0, 11'h000, 4'h1);
        tbl[36] = mk(4'h0, 4'hF, 1, 2'd0, 11'h061, 11'h061, 0, 0, 11'h000, 4'h0);

        // reset
        apply(1, 4'h0, 4'hF, 1, 2'd0, 11'h123);
        tick(); tick();
        apply(1, 4'h0, 4'hF, 1, 2'd0, 11'h123);
        chk("rst_pc_out", pc_out, 11'h123);
        chk("rst_in_service", in_service, 1'b0);
        chk("rst_pc_save", pc_save, 11'h000);
        chk("rst_active_id", active_id, 2'd0);
        chk("rst_pending", pending, 4'h0);
        tick();

        // directed table
        for (int k = 0; k < 37; k++) begin
            apply(0, tbl[k].irq, tbl[k].en, tbl[k].gie, tbl[k].mux, tbl[k].pcn);
            chk($sformatf("tbl%0d_pc_out", k), pc_out, tbl[k].e_pc);
            chk($sformatf("tbl%0d_in_service", k), in_service, tbl[k].e_srv);
            chk($sformatf("tbl%0d_active_id", k), active_id, tbl[k].e_id);
            chk($sformatf("tbl%0d_pc_save", k), pc_save, tbl[k].e_save);
            chk($sformatf("tbl%0d_pending", k), pending, tbl[k].e_pend);
            tick();
        end

        // reset mid-ISR at depth 2 with an edge still latched, then reti on empty stack
        apply(0, 4'h4, 4'hF, 1, 2'd0, 11'h100); tick();
        apply(0, 4'h0, 4'hF, 1, 2'd0, 11'h101);
        chk("seq_vec2", pc_out, 11'h008); tick();
        apply(0, 4'h2, 4'hF, 1, 2'd0, 11'h102); tick();
        apply(0, 4'h8, 4'hF, 1, 2'd0, 11'h103);
        chk("seq_vec1", pc_out, 11'h006); tick();
        apply(0, 4'h0, 4'hF, 1, 2'd0, 11'h104);
        chk("seq_depth2_id", active_id, 2'd1);
        chk("seq_depth2_save", pc_save, 11'h103);
        chk("seq_pend3", pending, 4'h8);
        tick();
        apply(1, 4'h1, 4'hF, 1, 2'd0, 11'h105);
        chk("seq_rst_pc_out", pc_out, 11'h105); tick();
        apply(0, 4'h0, 4'hF, 1, 2'd0, 11'h106);
        chk("seq_post_rst_srv", in_service, 1'b0);
        chk("seq_post_rst_save", pc_save, 11'h000);
        chk("seq_post_rst_id", active_id, 2'd0);
        chk("seq_post_rst_pend", pending, 4'h0);
        chk("seq_post_rst_pc", pc_out, 11'h106);
        tick();
        apply(0, 4'h0, 4'hF, 1, 2'd3, 11'h107);
        chk("seq_reti_empty_pc", pc_out, 11'h107); tick();
        apply(0, 4'h0, 4'hF, 1, 2'd0, 11'h108);
        chk("seq_reti_empty_srv", in_service, 1'b0);
        chk("seq_reti_empty_save", pc_save, 11'h000);
        chk("seq_reti_empty_pc2", pc_out, 11'h108);
        tick();

        // randomized traffic against the model
        for (int c = 0; c < 600; c++) begin
            apply(($urandom_range(0, 49) == 0),
                  4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15)),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'hF,
                  ($urandom_range(0, 9) != 0),
                  2'($urandom_range(0, 3)),
                  11'($urandom_range(0, 2047)));
            check_model();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
